// File: rtl/alu_mdu_pkg.sv
// Shared opcodes, FSM state type and opcode-class helpers for the execute unit.
package alu_mdu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [OP_W-1:0] ALU_SLL  = 5'd2;
    localparam logic [OP_W-1:0] ALU_SLT  = 5'd3;
    localparam logic [OP_W-1:0] ALU_SLTU = 5'd4;
    localparam logic [OP_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [OP_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [OP_W-1:0] ALU_SHA  = 5'd7;
    localparam logic [OP_W-1:0] ALU_OR   = 5'd8;
    localparam logic [OP_W-1:0] ALU_AND  = 5'd9;
    localparam logic [OP_W-1:0] ALU_A    = 5'd10;
    localparam logic [OP_W-1:0] ALU_B    = 5'd11;

    localparam logic [OP_W-1:0] MDU_MUL    = 5'd16;
    localparam logic [OP_W-1:0] MDU_MULH   = 5'd17;
    localparam logic [OP_W-1:0] MDU_MULHSU = 5'd18;
    localparam logic [OP_W-1:0] MDU_MULHU  = 5'd19;
    localparam logic [OP_W-1:0] MDU_DIV    = 5'd20;
    localparam logic [OP_W-1:0] MDU_DIVU   = 5'd21;
    localparam logic [OP_W-1:0] MDU_REM    = 5'd22;
    localparam logic [OP_W-1:0] MDU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_base(input logic [OP_W-1:0] op);
        return op < 5'd12;
    endfunction

    // 16..23 share the 10xxx prefix
    function automatic logic is_mdu(input logic [OP_W-1:0] op);
        return op[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_mdu_muldiv_iter.sv
// Radix-2 iterative engine: shift-add multiplier and restoring divider on
// unsigned magnitudes, sharing one XLEN+1-bit adder with carry out.
// The first iteration runs on the start edge straight from the inputs, so
// XLEN iterations finish XLEN-1 edges later; done then holds for one cycle.
module alu_mdu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                kill,
    input  logic                start,
    input  logic                is_div,
    input  logic [XLEN-1:0]     mag_a,
    input  logic [XLEN-1:0]     mag_b,
    output logic                done,
    output logic [2*XLEN-1:0]   acc
);

    localparam int CW = $clog2(XLEN);

    logic                busy_q, busy_d;
    logic                is_div_q, is_div_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;

    logic [2*XLEN-1:0]   src;
    logic [XLEN-1:0]     src_b;
    logic                src_div;
    logic [XLEN:0]       rem_sh;
    logic [XLEN:0]       add_a, add_b;
    logic                add_cin;
    logic [XLEN+1:0]     sum;
    logic [2*XLEN-1:0]   step_acc;

    // One iteration of the shared datapath; divide subtracts via ~b + 1
    always_comb begin
        src     = start ? {{XLEN{1'b0}}, mag_a} : acc_q;
        src_b   = start ? mag_b : b_q;
        src_div = start ? is_div : is_div_q;
        rem_sh  = src[2*XLEN-1:XLEN-1];
        if (src_div) begin
            add_a   = rem_sh;
            add_b   = ~{1'b0, src_b};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, src[2*XLEN-1:XLEN]};
            add_b   = src[0] ? {1'b0, src_b} : '0;
            add_cin = 1'b0;
        end
        sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_cin};
        if (src_div) begin
            // carry out means the shifted remainder was >= divisor
            if (sum[XLEN+1]) step_acc = {sum[XLEN-1:0], src[XLEN-2:0], 1'b1};
            else             step_acc = {rem_sh[XLEN-1:0], src[XLEN-2:0], 1'b0};
        end else begin
            step_acc = {sum[XLEN:0], src[XLEN-1:1]};
        end
    end

    // Start, down-count iterations, stop at terminal count; kill wins
    always_comb begin
        busy_d   = busy_q;
        is_div_d = is_div_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        if (kill) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d   = 1'b1;
            is_div_d = is_div;
            b_d      = mag_b;
            cnt_d    = CW'(XLEN - 1);
            acc_d    = step_acc;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
                acc_d = step_acc;
            end
        end
    end

    // Engine registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
        end
    end

    assign done = busy_q && (cnt_q == '0);
    assign acc  = acc_q;

endmodule

// File: rtl/alu_mdu.sv
// Handshaked EX-stage execute unit: single-cycle ALU ops plus iterative
// RV-M multiply/divide, registered result, synchronous flush.
//
// state | meaning
// IDLE  | no op held; ready for a request
// BUSY  | engine iterating on an M op
// DONE  | result registered and presented until taken or flushed
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              zero,
    output logic              illegal
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                neg_q, neg_d;

    logic                accept;
    logic                op_ill;
    logic [SHW-1:0]      shamt;
    logic [XLEN-1:0]     base_res;
    logic                a_neg, b_neg, res_neg;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf, div_short;
    logic [XLEN-1:0]     short_res;
    logic [XLEN-1:0]     fix_res;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;
    logic                md_start, md_done;
    logic [2*XLEN-1:0]   md_acc;
    logic                load, load_ill;
    logic [XLEN-1:0]     load_val;

    assign shamt     = b[SHW-1:0];
    assign op_ill    = !is_base(op) && !is_mdu(op);
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Single-cycle ALU datapath
    always_comb begin
        base_res = '0;
        case (op)
            ALU_ADD:  base_res = a + b;
            ALU_SUB:  base_res = a - b;
            ALU_SLL:  base_res = a << shamt;
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  base_res = a ^ b;
            ALU_SRL:  base_res = a >> shamt;
            ALU_SHA:  base_res = $signed(a) >>> shamt;
            ALU_OR:   base_res = a | b;
            ALU_AND:  base_res = a & b;
            ALU_A:    base_res = a;
            ALU_B:    base_res = b;
            default:  base_res = '0;
        endcase
    end

    // Operand magnitudes, result sign, and divide shortcuts
    always_comb begin
        a_neg = a[XLEN-1] && ((op == MDU_MULH) || (op == MDU_MULHSU) ||
                              (op == MDU_DIV)  || (op == MDU_REM));
        b_neg = b[XLEN-1] && ((op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM));
        mag_a = a_neg ? (~a + 1'b1) : a;
        mag_b = b_neg ? (~b + 1'b1) : b;
        res_neg = ((op == MDU_REM) || (op == MDU_REMU)) ? a_neg : (a_neg ^ b_neg);

        div_zero  = op[2] && is_mdu(op) && (b == '0);
        div_ovf   = ((op == MDU_DIV) || (op == MDU_REM)) && (a == MOST_NEG) && (&b);
        div_short = div_zero || div_ovf;
        short_res = '0;
        if (div_zero)  short_res = op[1] ? a : '1;
        else if (div_ovf) short_res = op[1] ? '0 : a;
    end

    // Sign fix-up of the engine accumulator
    always_comb begin
        prod    = neg_q ? (~md_acc + 1'b1) : md_acc;
        quo     = neg_q ? (~md_acc[XLEN-1:0] + 1'b1) : md_acc[XLEN-1:0];
        rem     = neg_q ? (~md_acc[2*XLEN-1:XLEN] + 1'b1) : md_acc[2*XLEN-1:XLEN];
        fix_res = '0;
        case (op_q)
            MDU_MUL:                          fix_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                fix_res = quo;
            MDU_REM, MDU_REMU:                fix_res = rem;
            default:                          fix_res = '0;
        endcase
    end

    // FSM next state and output-register loads; flush overrides everything
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        op_d      = op_q;
        neg_d     = neg_q;
        md_start  = 1'b0;
        load      = 1'b0;
        load_ill  = 1'b0;
        load_val  = '0;
        case (state_q)
            ST_BUSY: begin
                if (md_done) begin
                    load     = 1'b1;
                    load_val = fix_res;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                if ((state_q == ST_DONE) && out_ready) state_d = ST_IDLE;
                if (accept) begin
                    if (op_ill) begin
                        load     = 1'b1;
                        load_ill = 1'b1;
                        state_d  = ST_DONE;
                    end else if (!is_mdu(op) || div_short) begin
                        load     = 1'b1;
                        load_val = is_mdu(op) ? short_res : base_res;
                        state_d  = ST_DONE;
                    end else begin
                        md_start = 1'b1;
                        op_d     = op;
                        neg_d    = res_neg;
                        state_d  = ST_BUSY;
                    end
                end
            end
        endcase
        if (load) begin
            result_d  = load_val;
            zero_d    = (load_val == '0);
            illegal_d = load_ill;
        end
        if (flush) begin
            state_d   = ST_IDLE;
            md_start  = 1'b0;
            result_d  = result_q;
            zero_d    = zero_q;
            illegal_d = illegal_q;
            op_d      = op_q;
            neg_d     = neg_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            op_q      <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
        end
    end

    alu_mdu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .kill   (flush),
        .start  (md_start),
        .is_div (op[2]),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .done   (md_done),
        .acc    (md_acc)
    );

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked execute unit: the full integer ALU op set plus RV-M multiply/divide/remainder.
- Base ALU ops complete in 1 cycle. MUL*/DIV*/REM* use an iterative radix-2 engine.
- Sits in the EX stage and stalls the pipeline via in_ready/out_valid.
- Successor to the single-cycle combinational ALU: parametric XLEN, registered result, multi-cycle ops, flush.

Parameters:
- XLEN, 32: operand/result width; must be a power of two, at least 8.
- SHW, $clog2(XLEN): shift-amount bits taken from b.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill accepted/in-flight op; no result produced
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  5  opcode: 0-11 = ALU_ADD..ALU_B; 16-23 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- a  in  XLEN  operand A
- b  in  XLEN  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  result == 0, registered with result
- illegal  out  1  op was undefined (12-15, 24-31); qualified by out_valid

Behaviour:
- Reset (rst_n low, async): state IDLE; in_ready=1, out_valid=0, result=0, zero=0, illegal=0; engine registers cleared.
- Transfer rules:
  - Request transfer when in_valid && in_ready.
  - Result transfer when out_valid && out_ready.
  - result/zero/illegal are held stable while out_valid && !out_ready.
- FSM IDLE / BUSY / DONE:
  - IDLE, base op accepted: compute and register result this edge -> DONE. out_valid rises the next cycle (latency 1).
  - IDLE, undefined op: result=0, zero=1, illegal=1 -> DONE.
  - IDLE, M op accepted: latch operands -> BUSY with counter=XLEN-1. One iteration per cycle.
  - BUSY: counter==0 at an edge -> DONE. out_valid is first high XLEN+1 cycles after acceptance.
  - DONE: out_valid=1. On a result transfer -> IDLE, or accept a new request in that same cycle (back-to-back).
- in_ready = IDLE || (DONE && out_ready). No combinational path from in_valid to in_ready.
- Shortcuts (latency 1, straight to DONE, engine not started):
  - DIV/DIVU by 0 -> all ones; REM/REMU by 0 -> a.
  - DIV with a = most-negative, b = -1 -> a; REM in that case -> 0.
- Arithmetic:
  - Shifts use b[SHW-1:0]; SHA is arithmetic; SLT signed; SLTU unsigned; results zero-extended to XLEN.
  - MUL returns the low XLEN bits of the 2*XLEN product.
  - MULH returns the high XLEN bits, signed x signed. MULHSU: signed a x unsigned b. MULHU: unsigned x unsigned.
  - Signed mul/div: operate on magnitudes, then negate at DONE.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a). Division truncates toward zero.
- flush:
  - Synchronous and highest priority. Forces IDLE and out_valid=0 next cycle; the result is discarded.
  - flush concurrent with in_valid: the request is not accepted.
  - flush in DONE drops the pending result even if out_ready=1 that cycle.
- Mid-operation async reset: abort immediately to reset values; no partial result is ever presented.

Decomposition:
- Shared constants (CONSTANT.v include): ALU_* codes 0-11 and new MDU_MUL..MDU_REMU codes 16-23, with a 5-bit op width define.
- Natural sub-module: muldiv_iter. Shift-add multiplier and restoring divider sharing one XLEN+1-bit adder.
  - Ports: start, operand magnitudes, is_div, busy/done, 2*XLEN accumulator out.
- alu_mdu holds the base-op datapath, the FSM, sign fix-up and the output registers.

Test Plan:
- ADD a=5, b=7, out_ready=1 -> out_valid 1 cycle later, result=12, zero=0. SUB 3-3 -> result=0, zero=1.
- SHA a=0x80000000, b=0x24 -> 0xF8000000 (uses b[4:0]=4). SLTU a=1, b=0xFFFFFFFF -> 1; SLT same operands -> 0.
- MULH a=0xFFFFFFFF (-1), b=2 -> 0xFFFFFFFF; MULHU same -> 0x00000001.
  - out_valid exactly 33 cycles after acceptance; in_ready=0 during BUSY.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU x/0 -> 0xFFFFFFFF at latency 1. DIV 0x80000000/-1 -> 0x80000000.
- out_ready held low 5 cycles in DONE -> result stable, in_ready=0.
  - Raise out_ready together with a new in_valid -> both transfer that cycle.
- flush at BUSY cycle 10 of a DIVU -> out_valid never rises, in_ready=1 next cycle.
  - rst_n pulse mid-MUL -> outputs reach reset values without waiting for clk.
  - Repeat both with XLEN=16: MUL latency is 17 cycles.
